// File: rtl/sort_pkg.sv
// ============================================================================
// Module : sort_pkg
// Brief  : Shared types and sizing helpers for the tag-keyed unsort network.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sort_pkg;

  localparam int NUMVALS_DEF = 16;
  localparam int SIZE_DEF    = 32;

  function automatic int lanes_f(input int numvals);
    return 2 * numvals;
  endfunction

  function automatic int idxw_f(input int numvals);
    return $clog2(2 * numvals);
  endfunction

  localparam int L_DEF    = lanes_f(NUMVALS_DEF);
  localparam int IDXW_DEF = idxw_f(NUMVALS_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SORT   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic [SIZE_DEF-1:0] value;
    logic [IDXW_DEF-1:0] tag;
  } lane_t;

endpackage

`default_nettype wire

// File: rtl/tagged_cmp_swap.sv
// ============================================================================
// Module : tagged_cmp_swap
// Brief  : Compare-exchange of two (value, tag) lanes; swaps only on strictly
//          greater tag, so equal tags keep their relative order.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tagged_cmp_swap #(
  parameter int SIZE = 32,
  parameter int IDXW = 5
) (
  input  logic            en,
  input  logic [SIZE-1:0] a_val,
  input  logic [IDXW-1:0] a_tag,
  input  logic [SIZE-1:0] b_val,
  input  logic [IDXW-1:0] b_tag,
  output logic [SIZE-1:0] lo_val,
  output logic [IDXW-1:0] lo_tag,
  output logic [SIZE-1:0] hi_val,
  output logic [IDXW-1:0] hi_tag
);

  logic w_swap;

  assign w_swap = en && (a_tag > b_tag);

  assign lo_val = w_swap ? b_val : a_val;
  assign lo_tag = w_swap ? b_tag : a_tag;
  assign hi_val = w_swap ? a_val : b_val;
  assign hi_tag = w_swap ? a_tag : b_tag;

endmodule

`default_nettype wire

// File: rtl/tagged_unsort.sv
// ============================================================================
// Module : tagged_unsort
// Brief  : Restores original lane order from tag-annotated sorted values using
//          a sequential odd-even transposition network, one phase per clock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tagged_unsort
  import sort_pkg::*;
#(
  parameter int NUMVALS = NUMVALS_DEF,
  parameter int SIZE    = SIZE_DEF,
  parameter int IDXW    = idxw_f(NUMVALS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2*NUMVALS*SIZE-1:0] sorted_vals,
  input  logic [2*NUMVALS*IDXW-1:0] sorted_tags,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [2*NUMVALS*SIZE-1:0] o
);

  localparam int              L          = lanes_f(NUMVALS);
  localparam logic [IDXW-1:0] LAST_PHASE = IDXW'(L - 1);

  typedef struct packed {
    logic [SIZE-1:0] value;
    logic [IDXW-1:0] tag;
  } lane_p_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       phase_q, phase_d;
  lane_p_t [L-1:0]       lane_q, lane_d, lane_net;
  lane_p_t [L-2:0]       cmp_lo, cmp_hi;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [L*SIZE-1:0]     o_q, o_d;
  logic                  perm_bad;

  // Unit k pairs lanes (k, k+1); even units fire on even phases, odd on odd.
  for (genvar k = 0; k < L - 1; k++) begin : g_cmp
    logic [SIZE-1:0] lo_val, hi_val;
    logic [IDXW-1:0] lo_tag, hi_tag;

    tagged_cmp_swap #(
      .SIZE (SIZE),
      .IDXW (IDXW)
    ) u_cmp (
      .en     (phase_q[0] == 1'(k % 2)),
      .a_val  (lane_q[k].value),
      .a_tag  (lane_q[k].tag),
      .b_val  (lane_q[k+1].value),
      .b_tag  (lane_q[k+1].tag),
      .lo_val (lo_val),
      .lo_tag (lo_tag),
      .hi_val (hi_val),
      .hi_tag (hi_tag)
    );

    assign cmp_lo[k] = '{value: lo_val, tag: lo_tag};
    assign cmp_hi[k] = '{value: hi_val, tag: hi_tag};
  end

  // Each lane takes its result from whichever unit owns it this phase.
  for (genvar k = 0; k < L; k++) begin : g_lane
    if (k == 0) begin : g_first
      assign lane_net[k] = phase_q[0] ? lane_q[k] : cmp_lo[k];
    end else if (k == L - 1) begin : g_last
      assign lane_net[k] = phase_q[0] ? lane_q[k] : cmp_hi[k-1];
    end else begin : g_mid
      assign lane_net[k] = (phase_q[0] == 1'(k % 2)) ? cmp_lo[k] : cmp_hi[k-1];
    end
  end

  always_comb begin
    perm_bad = 1'b0;
    for (int k = 0; k < L; k++) begin
      if (lane_q[k].tag != IDXW'(k)) perm_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    lane_d  = lane_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    o_d     = o_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < L; k++) begin
            lane_d[k].value = sorted_vals[k*SIZE +: SIZE];
            lane_d[k].tag   = sorted_tags[k*IDXW +: IDXW];
          end
          busy_d  = 1'b1;
          phase_d = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        lane_d = lane_net;
        if (phase_q == LAST_PHASE) begin
          state_d = FINISH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      FINISH: begin
        for (int k = 0; k < L; k++) begin
          o_d[k*SIZE +: SIZE] = lane_q[k].value;
        end
        err_d   = perm_bad;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      lane_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      lane_q  <= lane_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      o_q     <= o_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign o    = o_q;

endmodule

`default_nettype wire

// File: tb/tb_tagged_unsort.sv
// ============================================================================
// Module : tb_tagged_unsort
// Brief  : Directed vector table plus protocol and reset sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tagged_unsort;

  localparam int NV = 16;
  localparam int L  = 2 * NV;
  localparam int SZ = 32;
  localparam int IW = 5;
  localparam int NT = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [L*SZ-1:0]   vals;
  logic [L*IW-1:0]   tags;
  logic              busy;
  logic              done;
  logic              err;
  logic [L*SZ-1:0]   o;

  tagged_unsort #(
    .NUMVALS (NV),
    .SIZE    (SZ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sorted_vals (vals),
    .sorted_tags (tags),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .o           (o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [L*SZ-1:0] vals;
    logic [L*IW-1:0] tags;
    logic [L*SZ-1:0] exp_o;
    logic            exp_err;
  } vec_t;

  vec_t tbl[NT];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_o(input string nm, input logic [L*SZ-1:0] exp);
    int bad;
    bad = -1;
    n_vec++;
    for (int i = 0; i < L; i++) begin
      if (bad < 0 && o[i*SZ +: SZ] !== exp[i*SZ +: SZ]) bad = i;
    end
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s: slot %0d got %h, expected %h", nm, bad,
               o[bad*SZ +: SZ], exp[bad*SZ +: SZ]);
    end
  endtask

  task automatic launch(input logic [L*SZ-1:0] v, input logic [L*IW-1:0] t);
    @(negedge clk);
    vals  = v;
    tags  = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered one negedge after the accepting edge; lat counts further edges.
  task automatic wait_done(input bit chk_hold, input logic [L*SZ-1:0] hold_exp,
                           output int lat, output bit busy_ok, output bit hold_ok);
    lat     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (chk_hold && o !== hold_exp) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          ndone;
    bit          bok, hok;
    logic [31:0] orig [L];
    int          idx  [L];
    int          perm [L];
    int          tmp, j;

    rst   = 1'b0;
    start = 1'b0;
    vals  = '0;
    tags  = '0;

    // identity
    tbl[0].name = "identity";
    tbl[0].exp_err = 1'b0;
    for (int k = 0; k < L; k++) begin
      tbl[0].vals[k*SZ +: SZ]  = 32'(100 + k);
      tbl[0].tags[k*IW +: IW]  = IW'(k);
      tbl[0].exp_o[k*SZ +: SZ] = 32'(100 + k);
    end
    // full reverse
    tbl[1].name = "reverse";
    tbl[1].exp_err = 1'b0;
    for (int k = 0; k < L; k++) begin
      tbl[1].vals[k*SZ +: SZ]  = 32'hA000_0000 + 32'(k);
      tbl[1].tags[k*IW +: IW]  = IW'(L - 1 - k);
      tbl[1].exp_o[k*SZ +: SZ] = 32'hA000_0000 + 32'(L - 1 - k);
    end
    // round trip: sort a random original array by value, tag = original index
    tbl[2].name = "roundtrip";
    tbl[2].exp_err = 1'b0;
    for (int k = 0; k < L; k++) begin
      orig[k] = $urandom;
      idx[k]  = k;
    end
    for (int a = 1; a < L; a++) begin
      tmp = idx[a];
      j   = a - 1;
      while (j >= 0 && orig[idx[j]] > orig[tmp]) begin
        idx[j+1] = idx[j];
        j--;
      end
      idx[j+1] = tmp;
    end
    for (int k = 0; k < L; k++) begin
      tbl[2].vals[k*SZ +: SZ]  = orig[idx[k]];
      tbl[2].tags[k*IW +: IW]  = IW'(idx[k]);
      tbl[2].exp_o[k*SZ +: SZ] = orig[k];
    end
    // duplicate: lanes 3 and 4 carry tag 5, lane 5 carries 3, tag 4 missing
    tbl[3].name = "duplicate";
    tbl[3].exp_err = 1'b1;
    for (int k = 0; k < L; k++) begin
      tbl[3].vals[k*SZ +: SZ]  = 32'hD000_0000 + 32'(k);
      tbl[3].tags[k*IW +: IW]  = IW'(k);
      tbl[3].exp_o[k*SZ +: SZ] = 32'hD000_0000 + 32'(k);
    end
    tbl[3].tags[3*IW +: IW]  = 5'd5;
    tbl[3].tags[4*IW +: IW]  = 5'd5;
    tbl[3].tags[5*IW +: IW]  = 5'd3;
    tbl[3].exp_o[3*SZ +: SZ] = 32'hD000_0005;
    tbl[3].exp_o[4*SZ +: SZ] = 32'hD000_0003;
    tbl[3].exp_o[5*SZ +: SZ] = 32'hD000_0004;
    // random permutation
    tbl[4].name = "randperm";
    tbl[4].exp_err = 1'b0;
    for (int k = 0; k < L; k++) perm[k] = k;
    for (int k = L - 1; k > 0; k--) begin
      j       = int'($urandom_range(k, 0));
      tmp     = perm[k];
      perm[k] = perm[j];
      perm[j] = tmp;
    end
    for (int k = 0; k < L; k++) begin
      tbl[4].vals[k*SZ +: SZ]        = $urandom | 32'h1;
      tbl[4].tags[k*IW +: IW]        = IW'(perm[k]);
      tbl[4].exp_o[perm[k]*SZ +: SZ] = tbl[4].vals[k*SZ +: SZ];
    end

    // reset state
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk_o("reset o", '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NT; i++) begin
      launch(tbl[i].vals, tbl[i].tags);
      wait_done(1'b0, '0, lat, bok, hok);
      chk({tbl[i].name, " latency"}, lat, L + 1);
      chk({tbl[i].name, " busy_during"}, bok, 1);
      chk({tbl[i].name, " busy_at_done"}, busy, 0);
      chk_o({tbl[i].name, " o"}, tbl[i].exp_o);
      chk({tbl[i].name, " err"}, err, tbl[i].exp_err);
      @(negedge clk);
      chk({tbl[i].name, " done_pulse"}, done, 0);
    end

    // start held high for 5 cycles gives exactly one run
    @(negedge clk);
    vals  = tbl[1].vals;
    tags  = tbl[1].tags;
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (60) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("hold5 done_count", ndone, 1);
    chk_o("hold5 o", tbl[1].exp_o);

    // start in the done cycle is accepted; o holds until the second done
    launch(tbl[0].vals, tbl[0].tags);
    wait_done(1'b0, '0, lat, bok, hok);
    chk("b2b first latency", lat, L + 1);
    chk_o("b2b first o", tbl[0].exp_o);
    vals  = tbl[3].vals;
    tags  = tbl[3].tags;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1, tbl[0].exp_o, lat, bok, hok);
    chk("b2b second latency", lat, L + 1);
    chk("b2b o_held", hok, 1);
    chk_o("b2b second o", tbl[3].exp_o);
    chk("b2b second err", err, 1);

    // reset in the middle of SORT aborts the run
    launch(tbl[4].vals, tbl[4].tags);
    repeat (10) @(negedge clk);
    chk("pre_reset busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst err", err, 0);
    chk_o("midrst o", '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (50) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("midrst no_done", ndone, 0);
    launch(tbl[4].vals, tbl[4].tags);
    wait_done(1'b0, '0, lat, bok, hok);
    chk("postrst latency", lat, L + 1);
    chk_o("postrst o", tbl[4].exp_o);
    chk("postrst err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
